parity_engine: RTL
==================

// Module: parity_engine
// PURPOSE
//   Parametrised, multi-cycle parity generator/checker for the UART TX/RX datapaths.
//   Folds DATA_WIDTH bits BITS_PER_CYC at a time. Trades latency for adder-tree area and
//   toggle power. Supports even/odd/mark/space modes.
//   Optionally compares the result against a received parity bit (RX check).
//   Sits between the frame-data register and the serializer/deserializer FSM.
// PARAMETERS
//   DATA_WIDTH    16  frame data width in bits (>=1)
//   BITS_PER_CYC   4  bits folded per CALC cycle; must divide DATA_WIDTH
//   N (localparam) = DATA_WIDTH/BITS_PER_CYC, number of CALC cycles
// PORTS
//   CLK         in   1           system clock, all logic on rising edge
//   RST         in   1           synchronous reset, active-high
//   P_DATA      in   DATA_WIDTH  frame data, sampled on accept
//   IN_VALID    in   1           request to compute; accepted when IN_VALID && IN_READY
//   IN_READY    out  1           high only in IDLE
//   PAR_EN      in   1           parity enabled for this frame, sampled on accept
//   PAR_TYP     in   2           00 even, 01 odd, 10 mark(1), 11 space(0); sampled on accept
//   CHK_BIT     in   1           received parity bit for check, sampled on accept
//   parity_out  out  1           computed parity bit, held until next DONE
//   PAR_VALID   out  1           one-cycle pulse: parity_out/PAR_ERR updated
//   PAR_ERR     out  1           PAR_EN_q && (parity_out != CHK_BIT_q), qualified by PAR_VALID
//   BUSY        out  1           high in CALC and DONE
// BEHAVIOUR
//   Reset: RST=1 at an edge -> state IDLE, chunk counter 0, accumulator 0.
//     After reset: parity_out=0, PAR_VALID=0, PAR_ERR=0, BUSY=0, IN_READY=1.
//     Reset overrides every other input. It aborts CALC/DONE with no PAR_VALID pulse.
//   FSM states: IDLE -> CALC -> DONE -> IDLE. There are no other transitions.
//   IDLE: IN_READY=1.
//     On accept, capture P_DATA, PAR_EN, PAR_TYP and CHK_BIT into shadow registers.
//     Clear the accumulator and chunk counter, then go to CALC.
//   CALC: each edge XORs chunk[cnt] (bits cnt*BITS_PER_CYC +: BITS_PER_CYC) of the
//     shadow data into a 1-bit accumulator and increments cnt.
//     On the edge where cnt==N-1, go to DONE and register the result:
//       even  -> acc ^ chunk (total ones incl. parity is even)
//       odd   -> ~(acc ^ chunk)
//       mark  -> 1
//       space -> 0
//       PAR_EN_q=0 -> 0 (mode ignored)
//   Mark/space/disabled frames still take N CALC cycles, so latency is uniform.
//   DONE: PAR_VALID=1 for exactly this one cycle. PAR_ERR is valid this cycle.
//     Next edge goes to IDLE.
//   PAR_ERR: registered together with parity_out. It is held until the next DONE.
//     It is 0 whenever PAR_EN_q=0.
//   Latency: accept edge T0 -> PAR_VALID high in the cycle after edge T0+N.
//   Throughput: one frame per N+2 cycles. IN_VALID held high is accepted in the first IDLE cycle.
//   Inputs P_DATA, PAR_EN, PAR_TYP and CHK_BIT change during CALC/DONE -> ignored (shadowed).
//   IN_VALID outside IDLE -> ignored. There is no queuing.
//   Counter width is clog2(N) with a minimum of 1. N=1 is legal: CALC lasts one cycle.
//   No combinational path from any input to any output.
// TESTING (DATA_WIDTH=16, BITS_PER_CYC=4, N=4 unless noted)
//   1. P_DATA=16'h0007 with PAR_TYP=00, then 01, 10, 11 (PAR_EN=1):
//      parity_out=1, then 0, 1, 0. Each PAR_VALID comes exactly 4 cycles after accept.
//   2. P_DATA=16'hFFFF, even, CHK_BIT=1 -> parity_out=0, PAR_ERR=1.
//      Same frame with CHK_BIT=0 -> PAR_ERR=0. PAR_EN=0 -> parity_out=0, PAR_ERR=0.
//   3. IN_VALID held high with 3 frames 16'h0001, 16'h0003, 16'h8001 (even):
//      IN_READY low during CALC/DONE. Accepts are spaced 6 cycles. Results are 1, 0, 0.
//   4. Accept 16'h0001, then drive P_DATA=16'hFFFF and PAR_TYP=01 during CALC:
//      result stays even parity of 16'h0001 = 1.
//   5. RST pulsed on the 2nd CALC cycle: no PAR_VALID, all outputs 0, IN_READY=1.
//      The next frame 16'h0003 even gives 0.
//   6. Regression with DATA_WIDTH=8, BITS_PER_CYC=8 (N=1) and DATA_WIDTH=9,
//      BITS_PER_CYC=3 (N=3): random data vs reference ^P_DATA across all modes.

Source files
------------

// File: rtl/parity_engine.sv
// parity_engine: multi-cycle parity generator/checker that folds BITS_PER_CYC data bits
// per cycle and optionally compares the result against a received parity bit.
module parity_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int BITS_PER_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  CHK_BIT,
    output logic                  parity_out,
    output logic                  PAR_VALID,
    output logic                  PAR_ERR,
    output logic                  BUSY
);
    localparam int N     = DATA_WIDTH / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic [1:0]              par_typ_q, par_typ_d;
    logic                    chk_bit_q, chk_bit_d;
    logic                    acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    parity_q, parity_d;
    logic                    err_q, err_d;
    logic                    par_valid_q, par_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    fold_s;
    logic                    result_s;
    logic [BITS_PER_CYC-1:0] chunks_s [N];

    // Maps the folded data parity onto the selected parity mode; disabled frames give 0.
    function automatic logic apply_mode(input logic en, input logic [1:0] typ, input logic fold);
        logic r;
        r = 1'b0;
        if (!en) begin
            r = 1'b0;
        end else begin
            case (typ)
                2'b00:   r = fold;
                2'b01:   r = ~fold;
                2'b10:   r = 1'b1;
                2'b11:   r = 1'b0;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_chunk
        assign chunks_s[g] = data_q[g*BITS_PER_CYC +: BITS_PER_CYC];
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 2'b00;
            chk_bit_q   <= 1'b0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            parity_q    <= 1'b0;
            err_q       <= 1'b0;
            par_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            chk_bit_q   <= chk_bit_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            err_q       <= err_d;
            par_valid_q <= par_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, chunk folding and result registration; status flags follow the next state.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        chk_bit_d = chk_bit_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        err_d     = err_q;
        fold_s    = acc_q ^ (^chunks_s[cnt_q]);
        result_s  = apply_mode(par_en_q, par_typ_q, fold_s);
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    chk_bit_d = CHK_BIT;
                    acc_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = fold_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    parity_d = result_s;
                    err_d    = par_en_q & (result_s != chk_bit_q);
                end else begin
                    state_d  = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        par_valid_d = (state_d == ST_DONE);
    end

    assign IN_READY   = in_ready_q;
    assign BUSY       = busy_q;
    assign PAR_VALID  = par_valid_q;
    assign parity_out = parity_q;
    assign PAR_ERR    = err_q;

endmodule
